// File: rtl/lab3_chk_pkg.sv
// Shared definitions for the lab3 response checker: FSM state encodings and
// a saturating-increment helper used by the mismatch counter.
package lab3_chk_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_DONE  = 2'd2
  } chk_state_e;

  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max_v);
    return (v >= max_v) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/lab3_cov_tracker.sv
// Vector coverage tracker: one seen bit per truth-table row plus a count of
// distinct rows marked since the last clear.
module lab3_cov_tracker
#(
  parameter int N_IN = 4
)(
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            clr_i,
  input  logic            mark_i,
  input  logic [N_IN-1:0] vec_i,
  output logic [N_IN:0]   cov_cnt_o,
  output logic            all_seen_o
);

  localparam int DEPTH = 1 << N_IN;

  logic [DEPTH-1:0] seen_q;
  logic [N_IN:0]    cnt_q;
  logic             fresh;

  assign fresh      = mark_i && !seen_q[vec_i];
  assign cov_cnt_o  = cnt_q;
  // Look-ahead: high in the cycle whose mark completes coverage, so the
  // owner can close the run on the same edge the last row is recorded.
  assign all_seen_o = (cnt_q == (N_IN+1)'(DEPTH)) ||
                      (fresh && (cnt_q == (N_IN+1)'(DEPTH - 1)));

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      seen_q <= '0;
      cnt_q  <= '0;
    end else if (fresh) begin
      seen_q[vec_i] <= 1'b1;
      cnt_q         <= cnt_q + (N_IN+1)'(1);
    end
  end

endmodule

// File: rtl/lab3_response_checker.sv
// Truth-table response checker: compares each applied vector's 1-bit response
// against EXPECTED, tracks coverage and idle timeout, and reports pass/fail.
// Optional first-mismatch capture ports are enabled by FIRST_FAIL_CAPTURE_EN.
module lab3_response_checker
  import lab3_chk_pkg::*;
#(
  parameter int                    N_IN     = 4,
  parameter logic [(1<<N_IN)-1:0]  EXPECTED = '0,
  parameter int                    ERR_W    = 5,
  parameter int                    TIMEOUT  = 64
)(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             vec_valid_i,
  input  logic [N_IN-1:0]  vec_i,
  input  logic             f_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             pass_o,
  output logic             timeout_o,
  output logic [ERR_W-1:0] err_cnt_o,
  output logic [N_IN:0]    cov_cnt_o
`ifdef FIRST_FAIL_CAPTURE_EN
  ,
  output logic             fail_valid_o,
  output logic [N_IN-1:0]  fail_vec_o
`endif
);

  localparam int          TW      = $clog2(TIMEOUT + 1);
  localparam logic [31:0] ERR_MAX = (32'd1 << ERR_W) - 32'd1;

  chk_state_e       state_q;
  logic             busy_q, done_q, pass_q, timeout_q;
  logic [ERR_W-1:0] err_q, err_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic             sample, mismatch, clr, all_seen;

  assign sample   = (state_q == ST_CHECK) && vec_valid_i;
  assign mismatch = f_i ^ EXPECTED[vec_i];
  assign clr      = start_i && (state_q != ST_CHECK);
  assign err_d    = mismatch ? ERR_W'(sat_inc(32'(err_q), ERR_MAX)) : err_q;
  assign timer_d  = timer_q + TW'(1);

  lab3_cov_tracker #(.N_IN(N_IN)) u_cov (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .clr_i      (clr),
    .mark_i     (sample),
    .vec_i      (vec_i),
    .cov_cnt_o  (cov_cnt_o),
    .all_seen_o (all_seen)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      timeout_q <= 1'b0;
      err_q     <= '0;
      timer_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start_i) begin
            state_q   <= ST_CHECK;
            busy_q    <= 1'b1;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            timeout_q <= 1'b0;
            err_q     <= '0;
            timer_q   <= '0;
          end
        end
        ST_CHECK: begin
          // A sample always resets the timer, so completion beats timeout.
          if (sample) begin
            err_q   <= err_d;
            timer_q <= '0;
            if (all_seen) begin
              state_q <= ST_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              pass_q  <= (err_d == '0);
            end
          end else begin
            timer_q <= timer_d;
            if (timer_d == TW'(TIMEOUT)) begin
              state_q   <= ST_DONE;
              busy_q    <= 1'b0;
              done_q    <= 1'b1;
              timeout_q <= 1'b1;
              pass_q    <= 1'b0;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign pass_o    = pass_q;
  assign timeout_o = timeout_q;
  assign err_cnt_o = err_q;

`ifdef FIRST_FAIL_CAPTURE_EN
  logic            fail_valid_q;
  logic [N_IN-1:0] fail_vec_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || clr) begin
      fail_valid_q <= 1'b0;
      fail_vec_q   <= '0;
    end else if (sample && mismatch && !fail_valid_q) begin
      fail_valid_q <= 1'b1;
      fail_vec_q   <= vec_i;
    end
  end

  assign fail_valid_o = fail_valid_q;
  assign fail_vec_o   = fail_vec_q;
`endif

endmodule
